conv_encoder_frame: RTL and testbench
=====================================

Name: conv_encoder_frame

Overview:
Rate-1/2, constraint-length-3 convolutional encoder. It sits directly upstream of viterbi_decoder_top and converts 8-bit data bytes into the 16-bit codewords that the decoder samples on its data_in. It encodes serially, one information bit per clock, MSB first. It holds each completed codeword stable on data_out until the next codeword is complete.

Parameters:
- TERMINATE, 1: 1 clears encoder memory at every byte accept, so each frame starts in state 0 (decoder frame mode). 0 carries memory across bytes (continuous stream).
- G0, 3'b111: generator polynomial for the upper output bit of each pair (octal 7).
- G1, 3'b101: generator polynomial for the lower output bit of each pair (octal 5).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-low (asserted when 0)
- in_data  input  8  byte to encode
- in_valid  input  1  in_data valid
- in_ready  output  1  encoder can accept a byte
- data_out  output  16  last completed codeword, to viterbi_decoder_top data_in
- out_valid  output  1  one-cycle pulse when data_out updates
- busy  output  1  encoding in progress
- frame_count  output  8  completed codewords, mod 256

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; in_ready=1 after release; data_out=16'h0000; out_valid=0; busy=0; frame_count=0; encoder memory s1=s2=0; bit counter=0.
- Reset mid-frame aborts the frame. The partial codeword is discarded and data_out is cleared to 0.
- States are IDLE and ENC.
- IDLE:
  - in_ready=1, busy=0.
  - On an edge with in_valid=1, the byte is accepted into the shift register and the state moves to ENC with bit counter=0.
  - If TERMINATE=1, s1 and s2 are cleared on the same accept edge.
  - If in_valid=0, the state stays IDLE.
- ENC:
  - in_ready=0, busy=1. in_valid is ignored; the upstream source must hold the byte.
  - Each edge processes bit b = next MSB of the byte.
  - Upper bit c0 = parity of G0 & {b,s1,s2}. Lower bit c1 = parity of G1 & {b,s1,s2}. With the defaults, c0=b^s1^s2 and c1=b^s2.
  - The pair {c0,c1} is shifted into the accumulator, then s2<=s1 and s1<=b.
  - Bit k of the byte (k=0 is the MSB) maps to accumulator bits [15-2k : 14-2k].
- Completion: on the 8th ENC edge (counter=7):
  - data_out <= the complete accumulator.
  - out_valid=1 for exactly the following cycle.
  - frame_count increments and wraps 255->0.
  - State returns to IDLE.
- Latency: byte accepted at edge N; data_out and out_valid change at edge N+8.
- Throughput: one byte per 9 cycles minimum. The next accept can occur at edge N+9.
- data_out changes only at completion or reset. It is never exposed mid-encode. The downstream decoder samples it without a handshake, so it must stay stable between completions.
- When TERMINATE=0, memory persists across bytes and across idle periods. Only reset clears it.
- Bytes are encoded strictly in accept order. No bytes are dropped while the upstream obeys in_ready.

Test Plan:
- Reset, then in_data=8'hB0 with TERMINATE=1 -> 8 cycles after accept, data_out=16'hE170, out_valid pulses once, frame_count=1.
- Byte 8'h80 -> data_out=16'hEC00. Byte 8'hFF -> data_out=16'hDAAA. Byte 8'h00 -> data_out=16'h0000, with an out_valid pulse even though the value is unchanged.
- TERMINATE=0, bytes 8'hFF then 8'h00 -> 16'hDAAA then 16'h7000. With TERMINATE=1 the same two bytes give 16'hDAAA then 16'h0000.
- Hold in_valid=1 continuously -> accepts occur every 9 cycles, in_ready is low for exactly 8 cycles per frame, and data_out is stable between pulses.
- Assert rst low at the 4th ENC cycle -> outputs clear immediately (asynchronously) and no out_valid appears. After release, byte 8'hB0 still yields 16'hE170.
- Send 256 frames -> frame_count wraps to 0 on the 256th completion.

Source files
------------

// File: rtl/conv_encoder_frame.sv
// conv_encoder_frame
// Rate-1/2, constraint-length-3 convolutional encoder feeding viterbi_decoder_top.
// Each accepted byte is encoded serially, one bit per clock, MSB first. The
// completed 16-bit codeword is held on data_out until the next codeword is done.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-low
//   in_data     byte to encode (must be held by the source while busy)
//   in_valid    in_data valid
//   in_ready    encoder can accept a byte (IDLE)
//   data_out    last completed codeword, bit pair k at [15-2k:14-2k]
//   out_valid   one-cycle pulse when data_out updates
//   busy        encoding in progress
//   frame_count completed codewords, mod 256
module conv_encoder_frame #(
    parameter bit       TERMINATE = 1'b1,
    parameter bit [2:0] G0        = 3'b111,
    parameter bit [2:0] G1        = 3'b101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] data_out,
    output logic        out_valid,
    output logic        busy,
    output logic [7:0]  frame_count
);

    typedef enum logic [0:0] {StIdle, StEnc} state_e;

    state_e      state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [15:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic [15:0] data_out_q, data_out_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  frame_count_q, frame_count_d;

    logic       bit_cur;
    logic [2:0] taps;
    logic       c0;
    logic       c1;

    assign bit_cur = shreg_q[7];
    // Tap vector ordered so the generator MSB multiplies the current bit.
    assign taps    = {bit_cur, s1_q, s2_q};
    assign c0      = ^(G0 & taps);
    assign c1      = ^(G1 & taps);

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        s1_d          = s1_q;
        s2_d          = s2_q;
        data_out_d    = data_out_q;
        out_valid_d   = 1'b0;
        frame_count_d = frame_count_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    shreg_d = in_data;
                    cnt_d   = 3'd0;
                    state_d = StEnc;
                    if (TERMINATE) begin
                        s1_d = 1'b0;
                        s2_d = 1'b0;
                    end
                end
            end
            StEnc: begin
                // in_valid is ignored here; the source holds the byte.
                shreg_d = {shreg_q[6:0], 1'b0};
                acc_d   = {acc_q[13:0], c0, c1};
                s2_d    = s1_q;
                s1_d    = bit_cur;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    // Publish the full accumulator including this edge's pair.
                    data_out_d    = {acc_q[13:0], c0, c1};
                    out_valid_d   = 1'b1;
                    frame_count_d = frame_count_q + 8'd1;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            shreg_q       <= 8'h00;
            acc_q         <= 16'h0000;
            cnt_q         <= 3'd0;
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            data_out_q    <= 16'h0000;
            out_valid_q   <= 1'b0;
            frame_count_q <= 8'h00;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            data_out_q    <= data_out_d;
            out_valid_q   <= out_valid_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign busy        = (state_q == StEnc);
    assign data_out    = data_out_q;
    assign out_valid   = out_valid_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_conv_encoder_frame.sv
// Bench for conv_encoder_frame: a terminating instance and a continuous-stream
// instance share the same stimulus, and both are checked against hand-computed
// codewords.
module tb_conv_encoder_frame;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;

    logic        t_in_ready, t_out_valid, t_busy;
    logic [15:0] t_data_out;
    logic [7:0]  t_frame_count;
    logic        n_in_ready, n_out_valid, n_busy;
    logic [15:0] n_data_out;
    logic [7:0]  n_frame_count;

    int tests = 0;
    int fails = 0;
    int exp_fc = 0;

    conv_encoder_frame #(.TERMINATE(1'b1)) u_term (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (t_in_ready),
        .data_out    (t_data_out),
        .out_valid   (t_out_valid),
        .busy        (t_busy),
        .frame_count (t_frame_count)
    );

    conv_encoder_frame #(.TERMINATE(1'b0)) u_cont (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (n_in_ready),
        .data_out    (n_data_out),
        .out_valid   (n_out_valid),
        .busy        (n_busy),
        .frame_count (n_frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  din;
        logic [15:0] exp_t;
        logic [15:0] exp_n;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one byte, check latency, codewords, count, pulse width and hold.
    task automatic send(input logic [7:0] b, input logic [15:0] exp_t, input logic [15:0] exp_n,
                        input bit full_check);
        int          lat;
        bit          stable;
        logic [15:0] hold;
        lat = 0;
        while (!t_in_ready && lat < 20) begin
            tick();
            lat++;
        end
        if (full_check) chk("ready_before_send", {31'd0, t_in_ready}, 32'd1);
        hold     = t_data_out;
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 0;
        stable   = 1'b1;
        while (!t_out_valid && lat < 20) begin
            if (t_data_out !== hold || !t_busy || t_in_ready) stable = 1'b0;
            tick();
            lat++;
        end
        exp_fc = (exp_fc + 1) % 256;
        if (full_check) begin
            chk("latency", lat, 32'd8);
            chk("hold_while_encoding", {31'd0, stable}, 32'd1);
            chk("data_out_term", {16'd0, t_data_out}, {16'd0, exp_t});
            chk("data_out_cont", {16'd0, n_data_out}, {16'd0, exp_n});
        end
        chk("frame_count", {24'd0, t_frame_count}, exp_fc);
        tick();
        if (full_check) begin
            chk("pulse_width", {31'd0, t_out_valid}, 32'd0);
            chk("data_out_held", {16'd0, t_data_out}, {16'd0, exp_t});
        end
    endtask

    initial begin
        int          last_pulse;
        int          npulse;
        int          run;
        bit          stable;
        bit          saw_pulse;

        vecs[0] = '{8'hB0, 16'hE170, 16'hE170};
        vecs[1] = '{8'h80, 16'hEC00, 16'hEC00};
        vecs[2] = '{8'hFF, 16'hDAAA, 16'hDAAA};
        vecs[3] = '{8'h00, 16'h0000, 16'h7000};
        vecs[4] = '{8'hFF, 16'hDAAA, 16'hDAAA};
        vecs[5] = '{8'h00, 16'h0000, 16'h7000};

        rst      = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        #22;
        chk("rst_data_out", {16'd0, t_data_out}, 32'd0);
        chk("rst_out_valid", {31'd0, t_out_valid}, 32'd0);
        chk("rst_busy", {31'd0, t_busy}, 32'd0);
        chk("rst_frame_count", {24'd0, t_frame_count}, 32'd0);
        rst = 1'b1;
        tick();
        chk("rst_in_ready", {31'd0, t_in_ready}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].din, vecs[i].exp_t, vecs[i].exp_n, 1'b1);
        end

        // Back-to-back: in_valid held high, accepts every 9 cycles.
        in_data    = 8'hB0;
        in_valid   = 1'b1;
        last_pulse = -1;
        npulse     = 0;
        run        = 0;
        stable     = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (t_out_valid) begin
                if (last_pulse >= 0) chk("pulse_spacing", i - last_pulse, 32'd9);
                last_pulse = i;
                npulse++;
            end else if (npulse > 0 && t_data_out !== 16'hE170) begin
                stable = 1'b0;
            end
            if (!t_in_ready) begin
                run++;
            end else if (run > 0) begin
                chk("ready_low_run", run, 32'd8);
                run = 0;
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (t_out_valid) npulse++;
        end
        chk("b2b_pulses_min", {31'd0, npulse >= 4}, 32'd1);
        chk("b2b_stable", {31'd0, stable}, 32'd1);
        chk("b2b_data_out", {16'd0, t_data_out}, 32'h0000_E170);
        exp_fc = (exp_fc + npulse) % 256;
        chk("b2b_frame_count", {24'd0, t_frame_count}, exp_fc);

        // Reset at the 4th ENC cycle: asynchronous clear, no pulse afterwards.
        in_data  = 8'hFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_data_out", {16'd0, t_data_out}, 32'd0);
        chk("async_rst_busy", {31'd0, t_busy}, 32'd0);
        chk("async_rst_in_ready", {31'd0, t_in_ready}, 32'd1);
        chk("async_rst_frame_count", {24'd0, t_frame_count}, 32'd0);
        chk("async_rst_cont_data_out", {16'd0, n_data_out}, 32'd0);
        exp_fc = 0;
        tick();
        rst       = 1'b1;
        saw_pulse = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (t_out_valid || n_out_valid) saw_pulse = 1'b1;
        end
        chk("no_pulse_after_abort", {31'd0, saw_pulse}, 32'd0);
        send(8'hB0, 16'hE170, 16'hE170, 1'b1);

        // Frame counter wrap: 256 completions since reset return it to 0.
        for (int i = 1; i < 255; i++) begin
            send(8'h00, 16'h0000, 16'h0000, 1'b0);
        end
        chk("frame_count_255", {24'd0, t_frame_count}, 32'd255);
        send(8'h00, 16'h0000, 16'h0000, 1'b1);
        chk("frame_count_wrap", {24'd0, t_frame_count}, 32'd0);
        chk("frame_count_wrap_cont", {24'd0, n_frame_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
